lru_multiset: RTL and testbench

- Set-associative replacement controller.
- Keeps one true-LRU age matrix, one availability vector and one lock mask per set, for NUM_SETS sets of NUM_WAYS ways.
- Sits beside the cache tag array in the load/store unit.
- Reports the victim way for a store in the same cycle. State updates on the next clock edge.
- New relative to the single-set LRU:
  - set indexing;
  - per-way locking (locked ways are never allocated or evicted);
  - whole-set flush op;
  - allocation-failure flag;
  - deterministic reset of the age order.

---
 rtl/lru_pkg.sv | 18 +
 rtl/lru_set_state.sv | 81 ++++++++
 rtl/lru_multiset.sv | 117 +++++++++++
 tb/tb_lru_multiset.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/lru_pkg.sv
// Shared types and helpers for the multi-set LRU replacement controller.
package lru_pkg;

  typedef enum logic [1:0] {
    OP_FLUSH_SET  = 2'b00,
    OP_LOAD       = 2'b01,
    OP_STORE      = 2'b10,
    OP_INVALIDATE = 2'b11
  } ls_op_t;

  localparam int unsigned LRU_MAX_WAYS = 64;

  // Callers truncate the result to their own way count.
  function automatic logic [LRU_MAX_WAYS-1:0] lru_onehot(input int unsigned idx);
    return LRU_MAX_WAYS'(1) << idx;
  endfunction

endpackage

// File: rtl/lru_set_state.sv
// One set's replacement state: availability, lock mask and lower-triangle age matrix.
module lru_set_state
  import lru_pkg::*;
#(
  parameter int unsigned NUM_WAYS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_WAYS-1:0] active_i,
  input  logic [NUM_WAYS-1:0] alloc_i,
  input  logic [NUM_WAYS-1:0] inval_i,
  input  logic                flush_i,
  input  logic                lock_we_i,
  input  logic [NUM_WAYS-1:0] lock_mask_i,
  output logic [NUM_WAYS-1:0] avail_o,
  output logic [NUM_WAYS-1:0] lock_o,
  output logic [NUM_WAYS-1:0] oldest_o
);

  logic [NUM_WAYS-1:0] avail_q, avail_d;
  logic [NUM_WAYS-1:0] lock_q, lock_d;
  // newer_q[i][j] = 1 when way i was used after way j; only i > j is meaningful.
  logic [NUM_WAYS-1:0][NUM_WAYS-1:0] newer_q, newer_d;

  always_comb begin
    avail_d = avail_q;
    if (flush_i) begin
      avail_d = '1;
    end
    avail_d = (avail_d | inval_i) & ~alloc_i;
    lock_d  = lock_we_i ? lock_mask_i : lock_q;
    newer_d = newer_q;
    for (int i = 0; i < NUM_WAYS; i++) begin
      for (int j = 0; j < NUM_WAYS; j++) begin
        if (i <= j) begin
          newer_d[i][j] = 1'b0;
        end else if (active_i[i]) begin
          newer_d[i][j] = 1'b1;
        end else if (active_i[j]) begin
          newer_d[i][j] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      avail_q <= '1;
      lock_q  <= '0;
      for (int i = 0; i < NUM_WAYS; i++) begin
        for (int j = 0; j < NUM_WAYS; j++) begin
          newer_q[i][j] <= (i > j);
        end
      end
    end else begin
      avail_q <= avail_d;
      lock_q  <= lock_d;
      newer_q <= newer_d;
    end
  end

  // A way is oldest-eligible when every other unlocked way is newer than it.
  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++) begin
      oldest_o[w] = ~lock_q[w];
      for (int j = 0; j < NUM_WAYS; j++) begin
        if (j != w && !lock_q[j]) begin
          if (j > w) begin
            if (!newer_q[j][w]) oldest_o[w] = 1'b0;
          end else begin
            if (newer_q[w][j]) oldest_o[w] = 1'b0;
          end
        end
      end
    end
  end

  assign avail_o = avail_q;
  assign lock_o  = lock_q;

endmodule

// File: rtl/lru_multiset.sv
// Set-associative replacement controller: set decode, victim priority and per-set state.
module lru_multiset
  import lru_pkg::*;
#(
  parameter int unsigned NUM_WAYS = 4,
  parameter int unsigned NUM_SETS = 8,
  localparam int unsigned SET_W = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
  localparam int unsigned WAY_W = $clog2(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ls_valid_i,
  input  logic [1:0]          ls_op_i,
  input  logic [SET_W-1:0]    ls_set_i,
  input  logic [WAY_W-1:0]    ls_way_i,
  input  logic                lock_valid_i,
  input  logic [SET_W-1:0]    lock_set_i,
  input  logic [NUM_WAYS-1:0] lock_mask_i,
  output logic                lru_valid_o,
  output logic [NUM_WAYS-1:0] lru_way_o,
  output logic                lru_fail_o
);

  ls_op_t op;
  assign op = ls_op_t'(ls_op_i);

  logic [NUM_SETS-1:0] set_sel, lock_we;
  logic [NUM_WAYS-1:0] avail_a  [NUM_SETS];
  logic [NUM_WAYS-1:0] lock_a   [NUM_SETS];
  logic [NUM_WAYS-1:0] oldest_a [NUM_SETS];

  logic [NUM_WAYS-1:0] avail_s, lock_s, oldest_s;
  logic [NUM_WAYS-1:0] elig, free, victim, way_oh;
  logic [NUM_WAYS-1:0] active, alloc, inval;
  logic                hit, is_store, fail, found;

  // Out-of-range set indices match no set, so they neither update nor report.
  always_comb begin
    for (int s = 0; s < NUM_SETS; s++) begin
      set_sel[s] = ls_valid_i && (ls_set_i == SET_W'(s));
      lock_we[s] = lock_valid_i && (lock_set_i == SET_W'(s));
    end
  end

  always_comb begin
    avail_s  = '0;
    lock_s   = '0;
    oldest_s = '0;
    for (int s = 0; s < NUM_SETS; s++) begin
      if (set_sel[s]) begin
        avail_s  = avail_a[s];
        lock_s   = lock_a[s];
        oldest_s = oldest_a[s];
      end
    end
  end

  assign hit      = |set_sel;
  assign is_store = hit && (op == OP_STORE);
  assign elig     = ~lock_s;
  assign free     = elig & avail_s;
  assign fail     = is_store && !(|elig);
  assign way_oh   = NUM_WAYS'(lru_onehot(32'(ls_way_i)));

  // Free ways win by lowest index; otherwise fall back to the oldest unlocked way.
  always_comb begin
    victim = '0;
    found  = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (free[w] && !found) begin
        victim[w] = 1'b1;
        found     = 1'b1;
      end
    end
    if (!found) begin
      victim = oldest_s;
    end
  end

  always_comb begin
    active = '0;
    alloc  = '0;
    inval  = '0;
    unique case (op)
      OP_STORE: begin
        active = victim;
        alloc  = victim;
      end
      OP_LOAD:       active = way_oh;
      OP_INVALIDATE: inval  = way_oh;
      default: ;
    endcase
  end

  assign lru_valid_o = is_store;
  assign lru_fail_o  = fail;
  assign lru_way_o   = is_store ? victim : '0;

  for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
    lru_set_state #(
      .NUM_WAYS(NUM_WAYS)
    ) u_set (
      .clk         (clk),
      .reset       (reset),
      .active_i    (set_sel[s] ? active : '0),
      .alloc_i     (set_sel[s] ? alloc : '0),
      .inval_i     (set_sel[s] ? inval : '0),
      .flush_i     (set_sel[s] && (op == OP_FLUSH_SET)),
      .lock_we_i   (lock_we[s]),
      .lock_mask_i (lock_mask_i),
      .avail_o     (avail_a[s]),
      .lock_o      (lock_a[s]),
      .oldest_o    (oldest_a[s])
    );
  end

endmodule

// File: tb/tb_lru_multiset.sv
// Table-driven check of lru_multiset with a scoreboard of expected per-cycle outputs.
module tb_lru_multiset;
  import lru_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       ls_valid_i;
  logic [1:0] ls_op_i;
  logic [2:0] ls_set_i;
  logic [1:0] ls_way_i;
  logic       lock_valid_i;
  logic [2:0] lock_set_i;
  logic [3:0] lock_mask_i;
  logic       lru_valid_o;
  logic [3:0] lru_way_o;
  logic       lru_fail_o;

  lru_multiset #(
    .NUM_WAYS(4),
    .NUM_SETS(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ls_valid_i   (ls_valid_i),
    .ls_op_i      (ls_op_i),
    .ls_set_i     (ls_set_i),
    .ls_way_i     (ls_way_i),
    .lock_valid_i (lock_valid_i),
    .lock_set_i   (lock_set_i),
    .lock_mask_i  (lock_mask_i),
    .lru_valid_o  (lru_valid_o),
    .lru_way_o    (lru_way_o),
    .lru_fail_o   (lru_fail_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [1:0] op;
    logic [2:0] sidx;
    logic [1:0] way;
    logic       lv;
    logic [2:0] lset;
    logic [3:0] lmask;
    logic       ev;
    logic [3:0] ew;
    logic       ef;
  } vec_t;

  typedef struct {
    logic       v;
    logic [3:0] w;
    logic       f;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(logic r, logic vld, logic [1:0] op, logic [2:0] s, logic [1:0] w,
                              logic lv, logic [2:0] ls, logic [3:0] lm,
                              logic ev, logic [3:0] ew, logic ef);
    vec_t v;
    v.rst = r; v.vld = vld; v.op = op; v.sidx = s; v.way = w;
    v.lv = lv; v.lset = ls; v.lmask = lm; v.ev = ev; v.ew = ew; v.ef = ef;
    return v;
  endfunction

  function automatic void store(logic [2:0] s, logic [3:0] ew);
    vecs.push_back(mk(0, 1, OP_STORE, s, 0, 0, 0, 0, 1, ew, 0));
  endfunction
  function automatic void ld(logic [2:0] s, logic [1:0] w);
    vecs.push_back(mk(0, 1, OP_LOAD, s, w, 0, 0, 0, 0, 4'b0000, 0));
  endfunction
  function automatic void inv(logic [2:0] s, logic [1:0] w);
    vecs.push_back(mk(0, 1, OP_INVALIDATE, s, w, 0, 0, 0, 0, 4'b0000, 0));
  endfunction
  function automatic void fl(logic [2:0] s);
    vecs.push_back(mk(0, 1, OP_FLUSH_SET, s, 0, 0, 0, 0, 0, 4'b0000, 0));
  endfunction
  function automatic void lk(logic [2:0] s, logic [3:0] m);
    vecs.push_back(mk(0, 0, OP_STORE, 0, 0, 1, s, m, 0, 4'b0000, 0));
  endfunction

  // Drive one cycle, push its expectation, compare on the falling edge.
  task automatic apply(input vec_t v, input string name);
    exp_t e;
    reset        = v.rst;
    ls_valid_i   = v.vld;
    ls_op_i      = v.op;
    ls_set_i     = v.sidx;
    ls_way_i     = v.way;
    lock_valid_i = v.lv;
    lock_set_i   = v.lset;
    lock_mask_i  = v.lmask;
    sb.push_back('{v.ev, v.ew, v.ef});
    @(negedge clk);
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      if ({lru_valid_o, lru_way_o, lru_fail_o} !== {e.v, e.w, e.f}) begin
        n_fail++;
        $display("FAIL %s: got valid=%b way=%b fail=%b, expected valid=%b way=%b fail=%b",
                 name, lru_valid_o, lru_way_o, lru_fail_o, e.v, e.w, e.f);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; ls_valid_i = 0; ls_op_i = 0; ls_set_i = 0; ls_way_i = 0;
    lock_valid_i = 0; lock_set_i = 0; lock_mask_i = 0;
    repeat (2) @(posedge clk);
    #1;

    vecs.push_back(mk(0, 0, OP_STORE, 3, 0, 0, 0, 0, 0, 4'b0000, 0));
    store(3, 4'b0001); store(3, 4'b0010); store(3, 4'b0100); store(3, 4'b1000);
    store(3, 4'b0001);
    ld(3, 1);
    store(3, 4'b0100);
    lk(3, 4'b0101);
    store(3, 4'b1000);
    lk(3, 4'b1111);
    vecs.push_back(mk(0, 1, OP_STORE, 3, 0, 0, 0, 0, 1, 4'b0000, 1));
    lk(3, 4'b0000);
    store(3, 4'b0001);
    inv(3, 2);
    store(3, 4'b0100);
    fl(3);
    store(3, 4'b0001);
    store(5, 4'b0001);
    store(3, 4'b0010); store(3, 4'b0100); store(3, 4'b1000);
    inv(3, 0);
    vecs.push_back(mk(0, 1, OP_STORE, 3, 0, 1, 3, 4'b0001, 1, 4'b0001, 0));
    store(3, 4'b0010);
    inv(3, 0);
    store(3, 4'b0100);
    lk(3, 4'b1111);
    vecs.push_back(mk(0, 1, OP_STORE, 3, 0, 0, 0, 0, 1, 4'b0000, 1));
    // Reset cycle still reports from pre-reset state.
    vecs.push_back(mk(1, 1, OP_STORE, 3, 0, 0, 0, 0, 1, 4'b0000, 1));
    store(3, 4'b0001);
    store(5, 4'b0001);
    store(7, 4'b0001);
    store(0, 4'b0001);

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back loads reorder a full set before the next allocation.
    apply(mk(0, 1, OP_STORE, 0, 0, 0, 0, 0, 1, 4'b0010, 0), "fill1");
    apply(mk(0, 1, OP_STORE, 0, 0, 0, 0, 0, 1, 4'b0100, 0), "fill2");
    apply(mk(0, 1, OP_STORE, 0, 0, 0, 0, 0, 1, 4'b1000, 0), "fill3");
    apply(mk(0, 1, OP_LOAD, 0, 0, 0, 0, 0, 0, 4'b0000, 0), "load0");
    apply(mk(0, 1, OP_LOAD, 0, 2, 0, 0, 0, 0, 4'b0000, 0), "load2");
    apply(mk(0, 1, OP_STORE, 0, 0, 0, 0, 0, 1, 4'b0010, 0), "evict1");
    apply(mk(0, 1, OP_LOAD, 0, 3, 0, 0, 0, 0, 4'b0000, 0), "load3");
    apply(mk(0, 1, OP_STORE, 0, 0, 0, 0, 0, 1, 4'b0001, 0), "evict0");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
